// File: rtl/csd_otf_bin_conv.sv
// csd_otf_bin_conv
//   Digit-serial radix-2 signed-digit (CSD) to two's-complement converter.
//   Digits arrive MSB first. The conversion is done on the fly: two
//   candidate prefixes are kept, Q and QM = Q-1. Each new digit only selects
//   one of them and appends a bit, so no carry-propagate adder is needed.
//   After W digits the (W+1)-bit result is presented with a valid/ready
//   handshake and held until the consumer takes it.
//
// Parameters
//   W          number of signed digits per word (W >= 2); result is W+1 bits
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active-high, overrides every other input
//   in_valid   in_digit holds a digit this cycle
//   in_ready   converter can accept a digit (high while collecting)
//   in_digit   signed digit {p,n}: 00=0, 10=+1, 01=-1, 11=invalid (taken as 0)
//   out_valid  out_z/out_err hold a completed word
//   out_ready  consumer accepts the completed word
//   out_z      two's-complement value sum d_i*2^(W-1-i), i=0 is the MSB digit
//   out_err    at least one 11 digit was seen in this word
module csd_otf_bin_conv #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_digit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_z,
  output logic         out_err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  // Only the low W bits of Q and QM are ever shifted onward; the top bit of
  // the finished word only exists in q_next and is captured into out_z.
  logic [W-1:0]    q_reg;
  logic [W-1:0]    qm_reg;
  logic            err_reg;
  logic [W:0]      out_z_reg;
  logic            out_err_reg;
  logic            out_valid_reg;
  logic            in_ready_reg;

  logic [W:0]      q_next;
  logic [W-1:0]    qm_next;
  logic            err_next;
  logic            last_digit;

  // Digit selection: +1 extends Q, -1 extends QM (borrowing from the prefix),
  // 0 extends each candidate with itself. QM stays equal to Q-1.
  always_comb begin
    q_next  = {q_reg, 1'b0};
    qm_next = {qm_reg[W-2:0], 1'b1};
    case (in_digit)
      2'b10: begin
        q_next  = {q_reg, 1'b1};
        qm_next = {q_reg[W-2:0], 1'b0};
      end
      2'b01: begin
        q_next  = {qm_reg, 1'b1};
        qm_next = {qm_reg[W-2:0], 1'b0};
      end
      default: begin
        // 00 and the invalid 11 both convert as a zero digit
        q_next  = {q_reg, 1'b0};
        qm_next = {qm_reg[W-2:0], 1'b1};
      end
    endcase
    err_next   = err_reg | (in_digit == 2'b11);
    last_digit = (cnt_reg == CW'(W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= COLLECT;
      cnt_reg       <= '0;
      q_reg         <= '0;
      qm_reg        <= '1;
      err_reg       <= 1'b0;
      out_z_reg     <= '0;
      out_err_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (in_valid) begin
            q_reg   <= q_next[W-1:0];
            qm_reg  <= qm_next;
            err_reg <= err_next;
            if (last_digit) begin
              out_z_reg     <= q_next;
              out_err_reg   <= err_next;
              cnt_reg       <= '0;
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              in_ready_reg  <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        DONE: begin
          // Digits offered here are left untouched; the release edge itself
          // never accepts a digit because in_ready is still low.
          if (out_ready) begin
            q_reg         <= '0;
            qm_reg        <= '1;
            err_reg       <= 1'b0;
            state_reg     <= COLLECT;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= COLLECT;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_z     = out_z_reg;
  assign out_err   = out_err_reg;

endmodule
